// File: rtl/seq_detect_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_event_logger
// Purpose  : Timestamps each detection pulse from the sequence detector with a
//            free-running cycle counter. Timestamps are queued in a
//            first-word-fall-through FIFO that is drained over a valid/ready
//            handshake. Also keeps a saturating event count and a sticky
//            overflow flag for status reads.
//
// Ports    : clk          - single clock, rising edge
//            rst          - synchronous active-high reset (highest priority)
//            enable       - runs the timestamp counter and accepts detections
//            clr          - synchronous soft clear (FIFO, count, overflow, ts)
//            detected     - detection pulse; every high cycle is one event
//            ev_valid     - FIFO non-empty
//            ev_ready     - consumer takes the head entry this cycle
//            ev_timestamp - head FIFO entry, 0 when empty
//            ev_count     - total accepted detections, saturating
//            fifo_level   - entries held, 0..DEPTH
//            overflow     - sticky, an event was dropped on a full FIFO
//            irq          - (EVENT_IRQ_EN only) registered level/overflow irq
//
// Options  : define EVENT_IRQ_EN to add the irq output and IRQ_THRESH parameter
//
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_event_logger #(
    parameter int TS_WIDTH  = 16,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 8
`ifdef EVENT_IRQ_EN
    ,
    parameter int IRQ_THRESH = DEPTH / 2
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clr,
    input  logic                       detected,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [TS_WIDTH-1:0]        ev_timestamp,
    output logic [CNT_WIDTH-1:0]       ev_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
`ifdef EVENT_IRQ_EN
    ,
    output logic                       irq
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [TS_WIDTH-1:0]  r_ts;
    logic [TS_WIDTH-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]      r_wptr;
    logic [c_AW-1:0]      r_rptr;
    logic [c_LW-1:0]      r_level;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_overflow;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic            w_event;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [c_LW-1:0] w_level_nxt;

    assign w_event = enable & detected;
    assign w_pop   = (r_level != '0) & ev_ready;
    assign w_full  = (r_level == c_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers: timestamp, pointers, level, count, overflow
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ts       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (enable) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= w_level_nxt;
            // Dropped events are still counted; the counter sticks at all-ones.
            if (w_event && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: the pre-edge timestamp is the one captured for the event.
    // Contents need no reset; the head is masked while empty.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && !clr && w_push) begin
            r_mem[r_wptr] <= r_ts;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. ev_valid derives only from registered level, so there is no
    // combinational path from detected.
    // ------------------------------------------------------------------------
    assign ev_valid     = (r_level != '0);
    assign ev_timestamp = ev_valid ? r_mem[r_rptr] : '0;
    assign ev_count     = r_count;
    assign fifo_level   = r_level;
    assign overflow     = r_overflow;

`ifdef EVENT_IRQ_EN
    // ------------------------------------------------------------------------
    // Interrupt: evaluated on the post-edge level and overflow state.
    // ------------------------------------------------------------------------
    localparam logic [c_LW-1:0] c_THRESH = c_LW'(IRQ_THRESH);

    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_level_nxt >= c_THRESH) | r_overflow | w_drop;
        end
    end

    assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_event_logger
// Purpose  : Directed self-checking bench. Main instance uses default
//            parameters; a second instance (TS_WIDTH=4, CNT_WIDTH=3) covers
//            timestamp wrap and count saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_event_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, clr, detected, ev_ready;
    logic        ev_valid, overflow;
    logic [15:0] ev_timestamp;
    logic [7:0]  ev_count;
    logic [3:0]  fifo_level;

    logic        enable2, clr2, detected2, ev_ready2;
    logic        ev_valid2, overflow2;
    logic [3:0]  ev_timestamp2;
    logic [2:0]  ev_count2;
    logic [3:0]  fifo_level2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detect_event_logger #(.TS_WIDTH(16), .DEPTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr), .detected(detected),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_timestamp(ev_timestamp),
        .ev_count(ev_count), .fifo_level(fifo_level), .overflow(overflow)
    );

    seq_detect_event_logger #(.TS_WIDTH(4), .DEPTH(8), .CNT_WIDTH(3)) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .clr(clr2), .detected(detected2),
        .ev_valid(ev_valid2), .ev_ready(ev_ready2), .ev_timestamp(ev_timestamp2),
        .ev_count(ev_count2), .fifo_level(fifo_level2), .overflow(overflow2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic det, input logic rdy, input int n);
        detected = det;
        ev_ready = rdy;
        for (int i = 0; i < n; i++) tick();
        detected = 1'b0;
        ev_ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clr = 1'b0; detected = 1'b0; ev_ready = 1'b0;
        enable2 = 1'b0; clr2 = 1'b0; detected2 = 1'b0; ev_ready2 = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // ---------------- reset state
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_ts", 32'(ev_timestamp), 0);
        chk("rst_count", 32'(ev_count), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // ---------------- basic timestamping: events at ts 5 and 9
        enable = 1'b1;
        cyc(0, 0, 5);                     // ts 0..4
        chk("pre_valid", 32'(ev_valid), 0);
        cyc(1, 0, 1);                     // event at ts 5
        chk("t1_valid", 32'(ev_valid), 1);
        chk("t1_head5", 32'(ev_timestamp), 5);
        chk("t1_level1", 32'(fifo_level), 1);
        cyc(0, 0, 3);                     // ts 6..8
        cyc(1, 0, 1);                     // event at ts 9
        chk("t1_level2", 32'(fifo_level), 2);
        chk("t1_count2", 32'(ev_count), 2);
        chk("t1_head_hold", 32'(ev_timestamp), 5);
        cyc(0, 1, 1);
        chk("t1_head9", 32'(ev_timestamp), 9);
        cyc(0, 1, 1);
        chk("t1_empty_valid", 32'(ev_valid), 0);
        chk("t1_empty_head", 32'(ev_timestamp), 0);

        // ---------------- drain order and hold: ts 3,4,7
        do_clr();
        cyc(0, 0, 3);                     // ts 0..2
        cyc(1, 0, 2);                     // ts 3,4
        cyc(0, 0, 2);                     // ts 5,6
        cyc(1, 0, 1);                     // ts 7
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1);
            chk("t2_hold3", 32'(ev_timestamp), 3);
        end
        cyc(0, 1, 1);
        chk("t2_out4", 32'(ev_timestamp), 4);
        cyc(0, 1, 1);
        chk("t2_out7", 32'(ev_timestamp), 7);
        cyc(0, 1, 1);
        chk("t2_valid0", 32'(ev_valid), 0);
        chk("t2_level0", 32'(fifo_level), 0);

        // ---------------- overflow: 10 events at ts 0..9, no pops
        do_clr();
        cyc(1, 0, 10);
        chk("t3_level8", 32'(fifo_level), 8);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_count10", 32'(ev_count), 10);
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain", 32'(ev_timestamp), 32'(i));
            cyc(0, 1, 1);
        end
        chk("t3_drained", 32'(ev_valid), 0);
        chk("t3_ovf_sticky", 32'(overflow), 1);

        // ---------------- full with simultaneous push and pop
        do_clr();
        cyc(1, 0, 8);                     // ts 0..7
        chk("t4_full", 32'(fifo_level), 8);
        cyc(1, 1, 1);                     // push ts 8, pop ts 0
        chk("t4_level8", 32'(fifo_level), 8);
        chk("t4_no_ovf", 32'(overflow), 0);
        for (int i = 1; i <= 8; i++) begin
            chk("t4_drain", 32'(ev_timestamp), 32'(i));
            cyc(0, 1, 1);
        end
        chk("t4_empty", 32'(ev_valid), 0);

        // ---------------- wrap (TS_WIDTH=4) and saturation (CNT_WIDTH=3)
        enable2 = 1'b1;
        for (int i = 0; i < 15; i++) tick();   // ts2 0..14
        detected2 = 1'b1;
        tick(); tick();                        // events at ts2 15 and 0
        detected2 = 1'b0;
        chk("t5_level2", 32'(fifo_level2), 2);
        chk("t5_head15", 32'(ev_timestamp2), 15);
        ev_ready2 = 1'b1;
        tick();
        ev_ready2 = 1'b0;
        chk("t5_head0", 32'(ev_timestamp2), 0);
        detected2 = 1'b1;
        for (int i = 0; i < 7; i++) tick();    // 9 events in total
        detected2 = 1'b0;
        chk("t5_sat7", 32'(ev_count2), 7);

        // ---------------- clr priority over a coincident event
        do_clr();
        cyc(1, 0, 1);                     // event at ts 0
        chk("t6_pre_level", 32'(fifo_level), 1);
        clr = 1'b1;
        cyc(1, 0, 1);
        clr = 1'b0;
        chk("t6_valid0", 32'(ev_valid), 0);
        chk("t6_level0", 32'(fifo_level), 0);
        chk("t6_count0", 32'(ev_count), 0);
        chk("t6_ovf0", 32'(overflow), 0);
        cyc(1, 0, 1);                     // ts restarted at 0
        chk("t6_ts0", 32'(ev_timestamp), 0);

        // ---------------- rst mid-drain
        cyc(1, 0, 2);                     // ts 1,2
        cyc(0, 1, 1);
        chk("t7_level2", 32'(fifo_level), 2);
        enable = 1'b0;
        rst = 1'b1;
        cyc(0, 1, 1);
        rst = 1'b0;
        chk("t7_valid", 32'(ev_valid), 0);
        chk("t7_head", 32'(ev_timestamp), 0);
        chk("t7_count", 32'(ev_count), 0);
        chk("t7_level", 32'(fifo_level), 0);
        chk("t7_ovf", 32'(overflow), 0);

        // ---------------- enable=0 ignores detected and freezes ts
        cyc(1, 0, 3);
        chk("t8_level0", 32'(fifo_level), 0);
        chk("t8_count0", 32'(ev_count), 0);
        enable = 1'b1;
        cyc(1, 0, 1);
        chk("t8_ts_frozen", 32'(ev_timestamp), 0);
        chk("t8_count1", 32'(ev_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
